crc_sender: RTL and testbench

- Transmit-side CRC encoder. Each cycle it samples a BW-bit data word and appends a CRC_BW-bit CRC remainder to form a systematic codeword.
- The codeword and the CRC are both registered and presented to the channel one clock later.
- Sits between the data source and the serializer/channel model; its peer is the CRC checker on the receive side.

---
 rtl/crc_pkg.sv | 28 ++
 rtl/crc_calc.sv | 28 ++
 rtl/crc_sender.sv | 38 +++
 tb/tb_crc_sender.sv | 131 +++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared CRC constants, codeword layout and reference remainder function.
package crc_pkg;

  localparam int unsigned CRC_DATA_W = 4;
  localparam int unsigned CRC_REM_W  = 3;
  localparam int unsigned CRC_CODE_W = CRC_DATA_W + CRC_REM_W;
  localparam logic [CRC_REM_W-1:0] CRC_POLY = 3'b011;

  // Systematic codeword: data in the MSBs, remainder in the LSBs.
  typedef struct packed {
    logic [CRC_DATA_W-1:0] data;
    logic [CRC_REM_W-1:0]  crc;
  } codeword_t;

  // Remainder of {data, zeros} divided by {1'b1, CRC_POLY}; also used by the receive-side checker.
  function automatic logic [CRC_REM_W-1:0] crc_rem(input logic [CRC_DATA_W-1:0] data);
    logic [CRC_REM_W-1:0] r;
    logic                 fb;
    r = '0;
    for (int i = int'(CRC_DATA_W) - 1; i >= 0; i--) begin
      fb = r[CRC_REM_W-1] ^ data[i];
      r  = r << 1;
      if (fb) r = r ^ CRC_POLY;
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_calc.sv
// Combinational GF(2) divider: unrolled bitwise long division of the augmented message.
module crc_calc
  import crc_pkg::*;
#(
  parameter int unsigned BW                 = CRC_DATA_W,
  parameter int unsigned CRC_BW             = CRC_REM_W,
  parameter logic [CRC_BW-1:0] POLY         = CRC_POLY
) (
  input  logic [BW-1:0]     data,
  output logic [CRC_BW-1:0] rem
);

  logic [CRC_BW-1:0] r;
  logic              fb;

  // Shift one message bit in per step; reduce by the generator when the top bit falls out.
  always_comb begin
    r  = '0;
    fb = 1'b0;
    for (int i = int'(BW) - 1; i >= 0; i--) begin
      fb = r[CRC_BW-1] ^ data[i];
      r  = r << 1;
      if (fb) r = r ^ POLY;
    end
    rem = r;
  end

endmodule

// File: rtl/crc_sender.sv
// Transmit-side CRC encoder: registers {in, crc(in)} and crc(in) every cycle.
module crc_sender
  import crc_pkg::*;
#(
  parameter int unsigned BW         = CRC_DATA_W,
  parameter int unsigned CRC_BW     = CRC_REM_W,
  parameter logic [CRC_BW-1:0] POLY = CRC_POLY
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [BW-1:0]        in,
  output logic [BW+CRC_BW-1:0] out,
  output logic [CRC_BW-1:0]    CRC
);

  logic [CRC_BW-1:0] rem_c;

  crc_calc #(
    .BW     (BW),
    .CRC_BW (CRC_BW),
    .POLY   (POLY)
  ) u_crc_calc (
    .data (in),
    .rem  (rem_c)
  );

  // Single pipeline stage; reset clears both outputs immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out <= '0;
      CRC <= '0;
    end else begin
      out <= {in, rem_c};
      CRC <= rem_c;
    end
  end

endmodule

// File: tb/tb_crc_sender.sv
// Directed self-checking bench for crc_sender (x^3+x+1, 4-bit data).
module tb_crc_sender;

  logic       clk;
  logic       rstn;
  logic [3:0] in;
  logic [6:0] out;
  logic [2:0] CRC;

  int checks;
  int errors;

  crc_sender dut (
    .clk  (clk),
    .rstn (rstn),
    .in   (in),
    .out  (out),
    .CRC  (CRC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Long division of a 7-bit value by 1011, top bit first.
  function automatic logic [2:0] mod1011(input logic [6:0] v);
    logic [6:0] r;
    logic [6:0] g;
    r = v;
    for (int i = 6; i >= 3; i--) begin
      g = 7'b0001011 << (i - 3);
      if (r[i]) r = r ^ g;
    end
    return r[2:0];
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a word before the next edge, then sample just after it.
  task automatic step(input logic [3:0] v);
    @(negedge clk);
    in = v;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] dir_in  [5];
  logic [6:0] dir_out [5];
  logic [2:0] dir_crc [5];
  logic [2:0] g;

  initial begin
    checks = 0;
    errors = 0;
    dir_in[0] = 4'h1; dir_out[0] = 7'h0B; dir_crc[0] = 3'b011;
    dir_in[1] = 4'hD; dir_out[1] = 7'h69; dir_crc[1] = 3'b001;
    dir_in[2] = 4'h4; dir_out[2] = 7'h27; dir_crc[2] = 3'b111;
    dir_in[3] = 4'hF; dir_out[3] = 7'h7F; dir_crc[3] = 3'b111;
    dir_in[4] = 4'h0; dir_out[4] = 7'h00; dir_crc[4] = 3'b000;

    // Reset held with input toggling
    rstn = 1'b0;
    in   = 4'h0;
    #1;
    chk("rst_out_t0", out, 7'h00);
    chk("rst_crc_t0", 7'(CRC), 7'h00);
    for (int i = 0; i < 3; i++) begin
      step(4'(4'hD + i));
      chk("rst_out_hold", out, 7'h00);
      chk("rst_crc_hold", 7'(CRC), 7'h00);
    end
    @(negedge clk);
    rstn = 1'b1;

    // Single words with latency check: before the edge the old value, after it the new
    for (int i = 0; i < 5; i++) begin
      step(4'h0);
      @(negedge clk);
      in = dir_in[i];
      #3;
      chk("pre_edge_out", out, 7'h00);
      @(posedge clk);
      #1;
      chk("single_out", out, dir_out[i]);
      chk("single_crc", 7'(CRC), 7'(dir_crc[i]));
    end

    // Back-to-back stream, one new word per edge
    for (int i = 0; i < 5; i++) begin
      step(dir_in[i]);
      chk("stream_out", out, dir_out[i]);
      chk("stream_crc", 7'(CRC), 7'(dir_crc[i]));
    end

    // Exhaustive against the golden division, plus codeword property
    for (int v = 0; v < 16; v++) begin
      step(4'(v));
      g = mod1011({4'(v), 3'b000});
      chk("exh_out", out, {4'(v), g});
      chk("exh_crc", 7'(CRC), 7'(g));
      chk("exh_lsb_eq_crc", 7'(out[2:0]), 7'(CRC));
      chk("exh_codeword_rem", 7'(mod1011(out)), 7'h00);
    end

    // Asynchronous reset mid-stream while 0xD is held
    step(4'hD);
    chk("pre_rst_out", out, 7'h69);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst_out", out, 7'h00);
    chk("async_rst_crc", 7'(CRC), 7'h00);
    #1;
    rstn = 1'b1;
    #1;
    chk("post_release_no_edge", out, 7'h00);
    @(posedge clk);
    #1;
    chk("first_after_release_out", out, 7'h69);
    chk("first_after_release_crc", 7'(CRC), 7'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
